// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source.
// Pixel/line counters advance once per pix_ce tick. Every output is a flop
// whose D input is decoded from the *next* counter value. As a result,
// hpos/vpos/visible/sync/strobes always describe the same pixel.
// Optional feature macro: VGA_FRAME_COUNT_EN.
//   Defined   -> frame_count counts frame_start strobes and wraps 255->0.
//   Undefined -> frame_count is tied to 0.
module vga_timing_gen #(
  parameter int unsigned H_DISPLAY       = 640,
  parameter int unsigned H_FRONT         = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BACK          = 48,
  parameter int unsigned V_DISPLAY       = 480,
  parameter int unsigned V_BOTTOM        = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_TOP           = 33,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       visible,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  // Raster geometry. All decode compares are done on unsigned 10-bit values,
  // so H_TOTAL and V_TOTAL must not exceed 1024.
  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS_END  = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_DISPLAY + V_BOTTOM);
  localparam logic [9:0] V_SYNC_END = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

  // Pin level while a sync pulse is active, and the idle level.
  localparam logic SYNC_ON  = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       visible_q, visible_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       h_wrap, v_wrap;

  // Next counter position: hpos steps every tick, vpos steps on hpos wrap.
  always_comb begin
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    h_wrap = 1'b0;
    v_wrap = 1'b0;
    if (pix_ce) begin
      if (hpos_q == H_LAST) begin
        hpos_d = '0;
        h_wrap = 1'b1;
        if (vpos_q == V_LAST) begin
          vpos_d = '0;
          v_wrap = 1'b1;
        end else begin
          vpos_d = vpos_q + 10'd1;
        end
      end else begin
        hpos_d = hpos_q + 10'd1;
      end
    end
  end

  // Decode outputs from the next position. They only change on a tick, so
  // idle clocks hold the levels and the strobes fall back to 0. vsync tracks
  // vpos, which only moves on an hpos wrap. This keeps vsync line-granular.
  always_comb begin
    visible_d     = visible_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_ce) begin
      visible_d     = (hpos_d < H_VIS_END) && (vpos_d < V_VIS_END);
      hsync_d       = ((hpos_d >= H_SYNC_BEG) && (hpos_d <= H_SYNC_END)) ? SYNC_ON : SYNC_OFF;
      vsync_d       = ((vpos_d >= V_SYNC_BEG) && (vpos_d <= V_SYNC_END)) ? SYNC_ON : SYNC_OFF;
      line_start_d  = h_wrap;
      frame_start_d = h_wrap && v_wrap;
    end
  end

  // Reset parks the raster on the last pixel so the first tick lands on (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hpos_q        <= H_LAST;
      vpos_q        <= V_LAST;
      visible_q     <= 1'b0;
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      visible_q     <= visible_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_count_q, frame_count_d;

  // Count on the same edge that raises frame_start. The first frame after
  // reset therefore reads 1. The 8-bit counter wraps naturally.
  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_start_d) begin
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = '0;
`endif

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign visible     = visible_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen.
// dut_a uses the 640x480 default timing; dut_b uses a tiny raster with
// active-high sync so that whole frames and the frame counter wrap fit in a
// short run.
module tb_vga_timing_gen;

`ifdef VGA_FRAME_COUNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       pce_a, pce_b;

  logic [9:0] a_hpos, a_vpos, b_hpos, b_vpos;
  logic       a_visible, a_hsync, a_vsync, a_line_start, a_frame_start;
  logic       b_visible, b_hsync, b_vsync, b_line_start, b_frame_start;
  logic [7:0] a_frame_count, b_frame_count;

  int total = 0;
  int bad   = 0;

  // ---------------- clock/reset block ----------------
  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst), .pix_ce(pce_a),
    .hpos(a_hpos), .vpos(a_vpos), .visible(a_visible),
    .hsync(a_hsync), .vsync(a_vsync),
    .line_start(a_line_start), .frame_start(a_frame_start),
    .frame_count(a_frame_count)
  );

  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_DISPLAY(2), .V_BOTTOM(1), .V_SYNC(1), .V_TOP(1),
    .SYNC_ACTIVE_LOW(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .pix_ce(pce_b),
    .hpos(b_hpos), .vpos(b_vpos), .visible(b_visible),
    .hsync(b_hsync), .vsync(b_vsync),
    .line_start(b_line_start), .frame_start(b_frame_start),
    .frame_count(b_frame_count)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Each task drives pix_ce, waits one clock edge, and samples 1 ns later.
  task automatic tick_a(input logic ce);
    pce_a = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_b(input logic ce);
    pce_b = ce;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hs_cnt, hs_first, hs_last, vis_off, vis_off_first, ls_extra, seq_err;
    int n, ls_at0, ls_at1, ls_num, hold_err;
    int vs_on, vs_bad, hs_on, hs_bad, vis_on, ls_cnt, fs_cnt, fs_frames, guard;
    logic [9:0] prev_h;
    logic       prev_vis, prev_hs;
    logic       reached;

    rst = 1'b1; pce_a = 1'b0; pce_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("a_rst_hpos", a_hpos, 799);
    check("a_rst_vpos", a_vpos, 524);
    check("a_rst_hsync", a_hsync, 1);
    check("a_rst_vsync", a_vsync, 1);
    check("a_rst_fc", a_frame_count, 0);
    check("b_rst_hpos", b_hpos, 6);
    check("b_rst_vpos", b_vpos, 4);
    check("b_rst_hsync", b_hsync, 0);
    check("b_rst_vsync", b_vsync, 0);
    #2 rst = 1'b0;

    // Run to hpos=300, then reset mid-line asynchronously.
    repeat (301) tick_a(1'b1);
    check("a_pre_rst_hpos", a_hpos, 300);
    check("a_pre_rst_vpos", a_vpos, 0);
    #2 rst = 1'b1;
    #1;
    check("a_async_hpos", a_hpos, 799);
    check("a_async_vpos", a_vpos, 524);
    check("a_async_vis", a_visible, 0);
    check("a_async_hsync", a_hsync, 1);
    check("a_async_vsync", a_vsync, 1);
    check("a_async_ls", a_line_start, 0);
    check("a_async_fs", a_frame_start, 0);
    pce_a = 1'b1;
    @(posedge clk);
    #1;
    check("a_rst_hold_hpos", a_hpos, 799);
    #2 rst = 1'b0;

    // First tick after release lands on (0,0) with both strobes.
    tick_a(1'b1);
    check("a_first_hpos", a_hpos, 0);
    check("a_first_vpos", a_vpos, 0);
    check("a_first_vis", a_visible, 1);
    check("a_first_ls", a_line_start, 1);
    check("a_first_fs", a_frame_start, 1);
    check("a_first_hsync", a_hsync, 1);

    // Scan the rest of line 0.
    hs_cnt = 0; hs_first = -1; hs_last = -1; vis_off = 0; vis_off_first = -1;
    ls_extra = 0; seq_err = 0;
    for (int i = 1; i < 800; i++) begin
      tick_a(1'b1);
      if (a_hpos != 10'(i) || a_vpos != 10'd0) seq_err++;
      if (a_hsync == 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(a_hpos);
        hs_last = int'(a_hpos);
      end
      if (!a_visible) begin
        vis_off++;
        if (vis_off_first < 0) vis_off_first = int'(a_hpos);
      end
      if (a_line_start || a_frame_start) ls_extra++;
    end
    check("line_hpos_seq", seq_err, 0);
    check("hsync_low_cnt", hs_cnt, 96);
    check("hsync_first", hs_first, 656);
    check("hsync_last", hs_last, 751);
    check("vis_off_cnt", vis_off, 160);
    check("vis_off_first", vis_off_first, 640);
    check("no_strobe_midline", ls_extra, 0);
    tick_a(1'b1);
    check("line1_hpos", a_hpos, 0);
    check("line1_vpos", a_vpos, 1);
    check("line1_ls", a_line_start, 1);
    check("line1_fs", a_frame_start, 0);

    // Advance to (799,10) and cross into line 11.
    n = 0; reached = 1'b0;
    while (!reached && n < 10000) begin
      tick_a(1'b1);
      n++;
      if (a_hpos == 10'd799 && a_vpos == 10'd10) reached = 1'b1;
    end
    check("reach_799_10", reached, 1);
    tick_a(1'b1);
    check("wrap11_hpos", a_hpos, 0);
    check("wrap11_vpos", a_vpos, 11);
    check("wrap11_ls", a_line_start, 1);
    check("wrap11_fs", a_frame_start, 0);
    check("wrap11_vsync", a_vsync, 1);

    // Alternate pix_ce. Ticks occur on odd clocks, so the 800th tick falls on
    // clock 1599 and the 1600th tick on clock 3199.
    ls_at0 = -1; ls_at1 = -1; ls_num = 0; hold_err = 0;
    for (int c = 0; c < 3300; c++) begin
      prev_h = a_hpos; prev_vis = a_visible; prev_hs = a_hsync;
      tick_a(c % 2 == 1);
      if (c % 2 == 0) begin
        if (a_hpos != prev_h || a_visible != prev_vis || a_hsync != prev_hs) hold_err++;
        if (a_line_start || a_frame_start) hold_err++;
      end
      if (a_line_start) begin
        ls_num++;
        if (ls_at0 < 0) ls_at0 = c;
        else if (ls_at1 < 0) ls_at1 = c;
      end
    end
    check("half_hold", hold_err, 0);
    check("half_ls_num", ls_num, 2);
    check("half_ls_first", ls_at0, 1599);
    check("half_line_period", ls_at1 - ls_at0, 1600);
    pce_a = 1'b0;

    // ---------- small raster: 7x5, frame = 35 ticks ----------
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick_b(1'b1);
    check("b_first_hpos", b_hpos, 0);
    check("b_first_vpos", b_vpos, 0);
    check("b_first_vis", b_visible, 1);
    check("b_first_ls", b_line_start, 1);
    check("b_first_fs", b_frame_start, 1);
    check("b_first_fc", b_frame_count, FC_EN ? 1 : 0);

    vs_on = 0; vs_bad = 0; hs_on = 0; hs_bad = 0; vis_on = 1; ls_cnt = 0; fs_cnt = 0;
    for (int i = 1; i < 35; i++) begin
      tick_b(1'b1);
      if (b_vsync) begin
        vs_on++;
        if (b_vpos != 10'd3) vs_bad++;
      end
      if (b_hsync) begin
        hs_on++;
        if (b_hpos != 10'd5) hs_bad++;
      end
      if (b_visible) vis_on++;
      if (b_line_start) ls_cnt++;
      if (b_frame_start) fs_cnt++;
      if (i == 34) begin
        check("b_penult_hpos", b_hpos, 6);
        check("b_penult_vpos", b_vpos, 4);
        check("b_penult_ls", b_line_start, 0);
      end
    end
    check("b_vsync_cnt", vs_on, 7);
    check("b_vsync_line", vs_bad, 0);
    check("b_hsync_cnt", hs_on, 5);
    check("b_hsync_pos", hs_bad, 0);
    check("b_vis_cnt", vis_on, 8);
    check("b_ls_cnt", ls_cnt, 4);
    check("b_fs_midframe", fs_cnt, 0);
    tick_b(1'b1);
    check("b_wrap_hpos", b_hpos, 0);
    check("b_wrap_vpos", b_vpos, 0);
    check("b_wrap_fs", b_frame_start, 1);
    check("b_fc_2", b_frame_count, FC_EN ? 2 : 0);

    // Run on to the 256th frame_start to see the counter wrap.
    fs_frames = 2; guard = 0;
    while (fs_frames < 256 && guard < 20000) begin
      tick_b(1'b1);
      guard++;
      if (b_frame_start) begin
        fs_frames++;
        if (fs_frames == 255) check("b_fc_255", b_frame_count, FC_EN ? 255 : 0);
        if (fs_frames == 256) check("b_fc_wrap", b_frame_count, 0);
      end
    end
    check("b_frames_reached", fs_frames, 256);
    tick_b(1'b0);
    check("b_fc_hold", b_frame_count, 0);
    check("b_fs_idle", b_frame_start, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
